// File: rtl/pcie_axi_mem_responder.sv
// AXI4 slave memory target (256-bit beats) at the far end of the PCIe outbound master.
// The write and read FSMs run independently and share one register-array memory.
module pcie_axi_mem_responder #(
    parameter int ID_WIDTH      = 6,
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 256,
    parameter int MEM_DEPTH_LG2 = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [ID_WIDTH-1:0]       s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic [1:0]                dbg_wr_state,
    output logic                      dbg_rd_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // once valid is raised, it and its payload hold until that transfer.
    localparam int DEPTH  = 1 << MEM_DEPTH_LG2;
    localparam int IW     = MEM_DEPTH_LG2;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [IW-1:0] IDX_ONE = 1;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    wr_state_t             wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [IW-1:0]         widx_q, widx_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;
    logic                  wfixed_q, wfixed_d;
    logic                  mem_we;

    rd_state_t             rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [IW-1:0]         ridx_q, ridx_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic                  rerr_q, rerr_d;
    logic                  rfixed_q, rfixed_d;

    // Size fields and address bits outside the beat index carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awsize, s_axi_arsize,
                                s_axi_awaddr[ADDR_WIDTH-1:IW+5], s_axi_awaddr[4:0],
                                s_axi_araddr[ADDR_WIDTH-1:IW+5], s_axi_araddr[4:0]};

    always_comb begin
        wr_state_d    = wr_state_q;
        wid_d         = wid_q;
        widx_d        = widx_q;
        wlen_d        = wlen_q;
        wcnt_d        = wcnt_q;
        werr_d        = werr_q;
        wfixed_d      = wfixed_q;
        mem_we        = 1'b0;
        s_axi_awready = (wr_state_q == W_IDLE);
        s_axi_wready  = (wr_state_q == W_DATA);
        s_axi_bvalid  = (wr_state_q == W_RESP);
        s_axi_bid     = wid_q;
        s_axi_bresp   = (wr_state_q == W_RESP && werr_q) ? RESP_SLVERR : RESP_OKAY;
        case (wr_state_q)
            W_IDLE: begin
                if (s_axi_awvalid) begin
                    wid_d      = s_axi_awid;
                    widx_d     = s_axi_awaddr[IW+4:5];
                    wlen_d     = s_axi_awlen;
                    wcnt_d     = 8'd0;
                    werr_d     = (s_axi_awburst == BURST_WRAP);
                    wfixed_d   = (s_axi_awburst == BURST_FIXED);
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    mem_we = 1'b1;
                    widx_d = wfixed_q ? widx_q : widx_q + IDX_ONE;
                    wcnt_d = wcnt_q + 8'd1;
                    if (s_axi_wlast) begin
                        if (wcnt_q != wlen_q) werr_d = 1'b1;
                        wr_state_d = W_RESP;
                    end else if (wcnt_q == wlen_q) begin
                        // The beat at len should have been last; anything further is overrun.
                        werr_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d    = rd_state_q;
        rid_d         = rid_q;
        ridx_d        = ridx_q;
        rlen_d        = rlen_q;
        rcnt_d        = rcnt_q;
        rerr_d        = rerr_q;
        rfixed_d      = rfixed_q;
        s_axi_arready = (rd_state_q == R_IDLE);
        s_axi_rvalid  = (rd_state_q == R_DATA);
        s_axi_rid     = rid_q;
        s_axi_rdata   = (rd_state_q == R_DATA) ? mem[ridx_q] : '0;
        s_axi_rlast   = (rd_state_q == R_DATA) && (rcnt_q == rlen_q);
        s_axi_rresp   = (rd_state_q == R_DATA && rerr_q) ? RESP_SLVERR : RESP_OKAY;
        case (rd_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    rid_d      = s_axi_arid;
                    ridx_d     = s_axi_araddr[IW+4:5];
                    rlen_d     = s_axi_arlen;
                    rcnt_d     = 8'd0;
                    rerr_d     = (s_axi_arburst == BURST_WRAP);
                    rfixed_d   = (s_axi_arburst == BURST_FIXED);
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    ridx_d = rfixed_q ? ridx_q : ridx_q + IDX_ONE;
                    rcnt_d = rcnt_q + 8'd1;
                    if (rcnt_q == rlen_q) rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wid_q      <= '0;
            widx_q     <= '0;
            wlen_q     <= '0;
            wcnt_q     <= '0;
            werr_q     <= 1'b0;
            wfixed_q   <= 1'b0;
            rd_state_q <= R_IDLE;
            rid_q      <= '0;
            ridx_q     <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
            rerr_q     <= 1'b0;
            rfixed_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wid_q      <= wid_d;
            widx_q     <= widx_d;
            wlen_q     <= wlen_d;
            wcnt_q     <= wcnt_d;
            werr_q     <= werr_d;
            wfixed_q   <= wfixed_d;
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            ridx_q     <= ridx_d;
            rlen_q     <= rlen_d;
            rcnt_q     <= rcnt_d;
            rerr_q     <= rerr_d;
            rfixed_q   <= rfixed_d;
        end
    end

    // Memory has no reset; a read in the commit cycle still sees the old contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[widx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign dbg_wr_state = wr_state_q;
    assign dbg_rd_state = rd_state_q;

endmodule
